// File: rtl/opb_arb_pkg.sv
// Shared types and helpers for the OPB round-robin arbiter and its reusers.
// Holds the FSM state encoding, default timing constants and the one-hot helper.
package opb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANTED = 2'd1,
        XFER    = 2'd2
    } arb_state_t;

    localparam int DEF_TIMEOUT     = 16;
    localparam int DEF_SELECT_WAIT = 4;
    localparam int MAX_MASTERS     = 8;

    // Callers narrow the result to their own master count with a size cast.
    function automatic logic [MAX_MASTERS-1:0] onehot_from_index(input logic [2:0] idx);
        logic [MAX_MASTERS-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/opb_rr_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: the first set request searching
// upward from ptr+1 with wrap-around wins; valid is low when nothing is requested.
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [PW-1:0] idx,
    output logic          valid
);

    int cand;

    // Walk from the farthest candidate to the nearest so the nearest set bit wins.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        cand  = 0;
        for (int i = N; i >= 1; i--) begin
            cand = (int'(ptr) + i) % N;
            if (req[cand]) begin
                idx   = PW'(cand);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/opb_rr_arbiter.sv
// Round-robin OPB arbiter with registered one-hot grants, bus-lock hold,
// select-wait revocation and a no-acknowledge transfer watchdog.
module opb_rr_arbiter
    import opb_arb_pkg::*;
#(
    parameter int C_NUM_MASTERS = 4,
    parameter int C_TIMEOUT     = DEF_TIMEOUT,
    parameter int C_SELECT_WAIT = DEF_SELECT_WAIT
) (
    input  logic                     OPB_Clk,
    input  logic                     OPB_Rst,
    input  logic [C_NUM_MASTERS-1:0] M_request,
    input  logic                     M_busLock,
    input  logic                     OPB_select,
    input  logic                     Sl_xferAck,
    input  logic                     Sl_retry,
    input  logic                     Sl_toutSup,
    output logic [C_NUM_MASTERS-1:0] OPB_MGrant,
    output logic                     OPB_timeout,
    output logic                     arb_busy,
    output arb_state_t               arb_state
);

    localparam int PW = $clog2(C_NUM_MASTERS);
    localparam int WW = $clog2(C_TIMEOUT + 1);
    localparam int SW = 4;

    arb_state_t               state;
    logic [PW-1:0]            ptr;
    logic [SW-1:0]            wait_cnt;
    logic [WW-1:0]            wd;
    logic [WW-1:0]            wd_next;
    logic [C_NUM_MASTERS-1:0] grant;
    logic                     timeout;

    logic [PW-1:0]            pick_idx;
    logic                     pick_valid;
    logic [C_NUM_MASTERS-1:0] pick_oh;
    logic                     owner_req;

    rr_pick #(
        .N  (C_NUM_MASTERS),
        .PW (PW)
    ) u_pick (
        .req   (M_request),
        .ptr   (ptr),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    assign pick_oh   = C_NUM_MASTERS'(onehot_from_index(3'(pick_idx)));
    // ptr always names the current owner while a grant is outstanding.
    assign owner_req = M_request[ptr];

    // Ack/retry restart the watchdog, toutSup freezes it, otherwise it counts
    // up and saturates at C_TIMEOUT so it cannot fire twice.
    always_comb begin
        wd_next = wd;
        if (Sl_xferAck || Sl_retry) begin
            wd_next = '0;
        end else if (Sl_toutSup) begin
            wd_next = wd;
        end else if (wd != WW'(C_TIMEOUT)) begin
            wd_next = wd + 1'b1;
        end
    end

    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            state    <= IDLE;
            ptr      <= PW'(C_NUM_MASTERS - 1);
            wait_cnt <= '0;
            wd       <= '0;
            grant    <= '0;
            timeout  <= 1'b0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    wait_cnt <= '0;
                    wd       <= '0;
                    if (pick_valid) begin
                        grant <= pick_oh;
                        ptr   <= pick_idx;
                        state <= GRANTED;
                    end
                end
                GRANTED: begin
                    if (OPB_select) begin
                        // The select cycle itself already counts toward the watchdog.
                        state    <= XFER;
                        wait_cnt <= '0;
                        wd       <= wd_next;
                    end else if (!owner_req || wait_cnt == SW'(C_SELECT_WAIT - 1)) begin
                        state    <= IDLE;
                        grant    <= '0;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                XFER: begin
                    if (OPB_select) begin
                        wd <= wd_next;
                        if (wd_next == WW'(C_TIMEOUT) && wd != WW'(C_TIMEOUT)) begin
                            timeout <= 1'b1;
                        end
                    end else begin
                        wd <= '0;
                        if (M_busLock && owner_req) begin
                            state    <= GRANTED;
                            wait_cnt <= '0;
                        end else begin
                            state <= IDLE;
                            grant <= '0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                end
            endcase
        end
    end

    assign OPB_MGrant  = grant;
    assign OPB_timeout = timeout;
    assign arb_busy    = (state != IDLE);
    assign arb_state   = state;

endmodule

// File: tb/tb_opb_rr_arbiter.sv
// Directed bench for opb_rr_arbiter: grant latency, round-robin order, watchdog,
// bus lock, select-wait revocation and reset in the middle of a transfer.
module tb_opb_rr_arbiter;
    import opb_arb_pkg::*;

    localparam int NM = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [NM-1:0] req;
    logic          lock, sel, ack, retry, tsup;
    logic [NM-1:0] grant;
    logic          tout, busy;
    arb_state_t    st;

    int total = 0;
    int bad   = 0;
    logic [NM-1:0] exp_q[$];

    always #5 clk = ~clk;

    opb_rr_arbiter #(
        .C_NUM_MASTERS (NM),
        .C_TIMEOUT     (16),
        .C_SELECT_WAIT (4)
    ) dut (
        .OPB_Clk     (clk),
        .OPB_Rst     (rst),
        .M_request   (req),
        .M_busLock   (lock),
        .OPB_select  (sel),
        .Sl_xferAck  (ack),
        .Sl_retry    (retry),
        .Sl_toutSup  (tsup),
        .OPB_MGrant  (grant),
        .OPB_timeout (tout),
        .arb_busy    (busy),
        .arb_state   (st)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Outputs are sampled 1 time unit after the rising edge; inputs change there too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; lock = 1'b0; sel = 1'b0;
        ack = 1'b0; retry = 1'b0; tsup = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    int pulses;

    initial begin
        do_reset();
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_tout", 32'(tout), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_state", 32'(st), 32'(IDLE));

        // Single request: grant one cycle later, held through a 3-cycle transfer.
        step(); step(); step();
        req = 4'b0001;
        step();
        check("single_grant", 32'(grant), 32'h1);
        check("single_state", 32'(st), 32'(GRANTED));
        check("single_busy", 32'(busy), 32'h1);
        sel = 1'b1;
        step();
        check("single_xfer", 32'(st), 32'(XFER));
        step();
        ack = 1'b1;
        step();
        check("single_hold", 32'(grant), 32'h1);
        sel = 1'b0; ack = 1'b0; req = '0;
        step();
        check("single_drop", 32'(grant), 32'h0);
        check("single_idle", 32'(st), 32'(IDLE));

        // Contention: all four request, 2-cycle transfers, one dead cycle between owners.
        do_reset();
        exp_q = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        req = 4'b1111;
        for (int r = 0; r < 5; r++) begin
            check($sformatf("rr_dead_%0d", r), 32'(grant), 32'h0);
            step();
            check($sformatf("rr_grant_%0d", r), 32'(grant), 32'(exp_q.pop_front()));
            sel = 1'b1;
            step();
            step();
            sel = 1'b0;
            step();
        end
        req = '0;

        // Watchdog: pulse exactly once, 16 cycles after select rose.
        do_reset();
        req = 4'b0001;
        step();
        sel = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            step();
            check($sformatf("tout_%0d", i), 32'(tout), (i == 16) ? 32'h1 : 32'h0);
        end
        sel = 1'b0; req = '0;
        step();

        // Ack in the cycle that would have fired: no pulse, count restarts.
        do_reset();
        req = 4'b0001;
        step();
        sel = 1'b1;
        pulses = 0;
        for (int i = 1; i <= 32; i++) begin
            ack = (i == 16);
            step();
            if (i < 32) pulses += int'(tout);
        end
        ack = 1'b0;
        check("ack_wins_pulses", 32'(pulses), 32'h0);
        check("ack_restart_tout", 32'(tout), 32'h1);
        sel = 1'b0; req = '0;
        step();

        // Timeout suppress held throughout: never fires.
        do_reset();
        req = 4'b0001;
        tsup = 1'b1;
        step();
        sel = 1'b1;
        pulses = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            pulses += int'(tout);
        end
        check("toutsup_pulses", 32'(pulses), 32'h0);
        sel = 1'b0; tsup = 1'b0; req = '0;
        step();

        // Bus lock: master 2 keeps the bus across three transfers while master 0 waits.
        do_reset();
        req = 4'b0100;
        step();
        check("lock_first", 32'(grant), 32'h4);
        req = 4'b0101;
        lock = 1'b1;
        for (int t = 0; t < 3; t++) begin
            sel = 1'b1;
            step();
            check($sformatf("lock_xfer_%0d", t), 32'(grant), 32'h4);
            step();
            sel = 1'b0;
            step();
            check($sformatf("lock_regrant_%0d", t), 32'(grant), 32'h4);
            check($sformatf("lock_state_%0d", t), 32'(st), 32'(GRANTED));
        end
        lock = 1'b0;
        req = 4'b0001;
        sel = 1'b1;
        step();
        step();
        sel = 1'b0;
        step();
        check("unlock_idle", 32'(grant), 32'h0);
        step();
        check("unlock_next", 32'(grant), 32'h1);
        req = '0;
        step();

        // Select never asserted: grant held 4 cycles, then revoked, next requester served.
        do_reset();
        req = 4'b0110;
        step();
        check("nosel_grant", 32'(grant), 32'h2);
        for (int i = 1; i <= 3; i++) begin
            step();
            check($sformatf("nosel_hold_%0d", i), 32'(grant), 32'h2);
        end
        step();
        check("nosel_revoke", 32'(grant), 32'h0);
        step();
        check("nosel_next", 32'(grant), 32'h4);
        req = '0;
        step();

        // Reset while the watchdog sits at 10 mid-transfer.
        do_reset();
        req = 4'b0100;
        step();
        sel = 1'b1;
        for (int i = 0; i < 10; i++) step();
        check("midx_state", 32'(st), 32'(XFER));
        rst = 1'b1;
        step();
        check("midx_grant", 32'(grant), 32'h0);
        check("midx_tout", 32'(tout), 32'h0);
        check("midx_busy", 32'(busy), 32'h0);
        rst = 1'b0; sel = 1'b0;
        req = 4'b1111;
        step();
        check("midx_first", 32'(grant), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/opb_rr_arbiter.md
# opb_rr_arbiter

Round-robin OPB bus arbiter with transfer watchdog. It shares the single OPB segment between up to C_NUM_MASTERS masters, which the PowerPC bridge and DMA engines use to reach the ppc2simulink/simulink2ppc register slaves. Grants are registered and one-hot, and bus-lock is honoured. A 16-cycle no-acknowledge timeout terminates hung transfers. It sits beside the OPB OR-combining logic, in the OPB clock domain.

## Interface
- C_NUM_MASTERS, 4: number of requesting masters, 2..8.
- C_TIMEOUT, 16: cycles of select-without-ack before OPB_timeout fires, 2..255.
- C_SELECT_WAIT, 4: cycles a granted master has to assert select before its grant is revoked, 1..15.
- OPB_Clk  in  1  sole clock, rising edge.
- OPB_Rst  in  1  reset; synchronous, active-high.
- M_request  in  C_NUM_MASTERS  per-master bus request.
- M_busLock  in  1  OR of master busLock; the current owner keeps the bus.
- OPB_select  in  1  OR of master select; a transfer is in progress.
- Sl_xferAck  in  1  OR of slave transfer acknowledge.
- Sl_retry  in  1  OR of slave retry.
- Sl_toutSup  in  1  OR of slave timeout suppress.
- OPB_MGrant  out  C_NUM_MASTERS  one-hot grant, registered.
- OPB_timeout  out  1  one-cycle pulse; the watchdog expired.
- arb_busy  out  1  high in any state except IDLE.

## Operation
- Reset values: OPB_MGrant = 0, OPB_timeout = 0, arb_busy = 0, state IDLE, rr pointer = C_NUM_MASTERS-1 (master 0 wins first), counters = 0.
- IDLE: if any M_request is set, pick the first set bit searching upward from pointer+1 with wrap. Set that grant bit and set pointer = winner. Go to GRANTED. If no request is set, grant stays 0 (no parking).
- GRANTED: wait counter increments each cycle.
  - OPB_select=1 → XFER, wait counter cleared.
  - Owner's request drops, or wait counter reaches C_SELECT_WAIT → grant 0, IDLE.
- XFER: watchdog counter rules, in priority order:
  - Sl_xferAck or Sl_retry → clear.
  - Sl_toutSup → hold.
  - Otherwise → increment.
  - Counter reaching C_TIMEOUT → OPB_timeout=1 for exactly one cycle. The counter saturates there and does not re-fire until cleared.
- XFER, OPB_select falls:
  - M_busLock=1 and owner's M_request=1 → GRANTED with the grant unchanged and no re-arbitration.
  - Otherwise → grant 0, IDLE.
- Lock overrides fairness: other requests are ignored while the lock holds.
- Requests arriving in GRANTED or XFER are only evaluated on the next IDLE cycle.
- Watchdog counter width: ceil(log2(C_TIMEOUT+1)); no overflow is possible because the counter saturates.

## Timing
- Request to grant: request sampled in IDLE at cycle N, OPB_MGrant valid at N+1.
- Release to next grant: select falls at N, grant drops at N+1 (IDLE), next grant at N+2. There is one dead cycle between owners; this is mandatory bus turnaround.
- Timeout: select high at N with no ack/retry/toutSup gives OPB_timeout at N+C_TIMEOUT.
- Sl_xferAck and OPB_timeout in the same cycle: ack wins, counter clears, no pulse.
- OPB_Rst at any cycle, including mid-XFER: all outputs read reset values on the next edge.

## Structure
- opb_arb_pkg holds:
  - the state enum IDLE/GRANTED/XFER;
  - default constants for C_TIMEOUT and C_SELECT_WAIT;
  - the one-hot-from-index function.
- Sub-module rr_pick: combinational round-robin priority encoder. Inputs are the request vector and the pointer; outputs are the winner index and a valid flag. It is reused by the register-bank scheduler.
- The top holds the FSM, the rr pointer, the wait counter, the watchdog counter and the grant register.

## Test plan
- Single request: M_request=0001 at cycle 5 → OPB_MGrant=0001 at cycle 6. Select held 3 cycles with ack → grant drops the cycle after select falls.
- Contention: M_request=1111 held continuously with 2-cycle transfers → grant order 0001, 0010, 0100, 1000, 0001, with one idle cycle between grants.
- Timeout: select high, no ack, toutSup=0 → OPB_timeout pulses exactly once, 16 cycles after select rose. A repeat run with toutSup=1 throughout → no pulse for 100 cycles.
- Bus lock: master 2 holds busLock and its request across three transfers while master 0 requests → grant stays 0100 throughout. After lock drops → 0001.
- Select never asserted: master 1 granted, select stays 0 → grant revoked after 4 cycles, then the next requester is served.
- Reset mid-XFER with watchdog at 10 → next cycle grant=0, timeout=0, arb_busy=0. After reset, master 0 wins first.
